// File: rtl/nf10_stamp_pkg.sv
// Shared constants, buffer state encoding and small helpers for the stamp inserter.
package nf10_stamp_pkg;

  localparam int unsigned DEF_AXIS_DATA_WIDTH  = 256;
  localparam int unsigned DEF_AXIS_TUSER_WIDTH = 128;
  localparam int unsigned DEF_TIMESTAMP_WIDTH  = 64;
  localparam int unsigned DEF_TS_LSB           = 64;
  localparam int unsigned STATS_WIDTH          = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

  // Saturating increment for the statistics counters.
  function automatic logic [STATS_WIDTH-1:0] sat_inc(input logic [STATS_WIDTH-1:0] v);
    return (v == '1) ? v : v + STATS_WIDTH'(1);
  endfunction

endpackage

// File: rtl/nf10_axis_skid_buf.sv
// Generic 2-entry registered slice: full throughput, registered ready and valid.
module nf10_axis_skid_buf
  import nf10_stamp_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  buf_state_t       state;
  logic [WIDTH-1:0] skid_q;
  logic             s_acc;
  logic             m_acc;

  assign s_acc = s_valid & s_ready;
  assign m_acc = m_valid & m_ready;

  // Occupancy FSM; valid and ready are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      m_valid <= 1'b0;
      s_ready <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          s_ready <= 1'b1;
          if (s_acc) begin
            state   <= ONE;
            m_valid <= 1'b1;
          end
        end
        ONE: begin
          if (s_acc && !m_acc) begin
            state   <= TWO;
            s_ready <= 1'b0;
          end else if (!s_acc && m_acc) begin
            state   <= EMPTY;
            m_valid <= 1'b0;
          end
        end
        TWO: begin
          if (m_acc) begin
            state   <= ONE;
            s_ready <= 1'b1;
          end
        end
        default: begin
          state   <= EMPTY;
          m_valid <= 1'b0;
          s_ready <= 1'b1;
        end
      endcase
    end
  end

  // Head register feeds the master; skid register catches the beat taken while stalled.
  always_ff @(posedge clk) begin
    if (s_acc && ((state == EMPTY) || ((state == ONE) && m_acc))) begin
      m_data <= s_data;
    end else if ((state == TWO) && m_acc) begin
      m_data <= skid_q;
    end
    if (s_acc && (state == ONE) && !m_acc) begin
      skid_q <= s_data;
    end
  end

endmodule

// File: rtl/nf10_stamp_inserter.sv
// Writes the stamp counter into TUSER of each packet's first beat; full-rate AXIS stage.
// Optional statistics counters are built when STAMP_INSERTER_STATS_EN is defined.
module nf10_stamp_inserter
  import nf10_stamp_pkg::*;
#(
  parameter int unsigned C_AXIS_DATA_WIDTH  = DEF_AXIS_DATA_WIDTH,
  parameter int unsigned C_AXIS_TUSER_WIDTH = DEF_AXIS_TUSER_WIDTH,
  parameter int unsigned TIMESTAMP_WIDTH    = DEF_TIMESTAMP_WIDTH,
  parameter int unsigned TS_LSB             = DEF_TS_LSB
) (
  input  logic                            axi_aclk,
  input  logic                            axi_reset,
  input  logic [TIMESTAMP_WIDTH-1:0]      stamp_counter,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  input  logic                            clr_stats,
  output logic [STATS_WIDTH-1:0]          pkt_count,
  output logic [STATS_WIDTH-1:0]          stall_count
);

  localparam int unsigned STRB_WIDTH = C_AXIS_DATA_WIDTH / 8;
  localparam int unsigned BEAT_WIDTH = C_AXIS_DATA_WIDTH + STRB_WIDTH + C_AXIS_TUSER_WIDTH + 1;

  if (TS_LSB + TIMESTAMP_WIDTH > C_AXIS_TUSER_WIDTH) begin : g_ts_range_err
    $error("nf10_stamp_inserter: TS_LSB + TIMESTAMP_WIDTH exceeds C_AXIS_TUSER_WIDTH");
  end

  logic                          sof;
  logic                          s_acc;
  logic [C_AXIS_TUSER_WIDTH-1:0] tuser_c;
  logic [BEAT_WIDTH-1:0]         m_beat;

  assign s_acc = s_axis_tvalid & s_axis_tready;

  // Start-of-frame tracker: the beat after a tlast (or reset) opens a packet.
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      sof <= 1'b1;
    end else if (s_acc) begin
      sof <= s_axis_tlast;
    end
  end

  always_comb begin
    tuser_c = s_axis_tuser;
    if (sof) begin
      tuser_c[TS_LSB +: TIMESTAMP_WIDTH] = stamp_counter;
    end
  end

  nf10_axis_skid_buf #(
    .WIDTH (BEAT_WIDTH)
  ) u_skid (
    .clk     (axi_aclk),
    .rst     (axi_reset),
    .s_data  ({s_axis_tdata, s_axis_tstrb, tuser_c, s_axis_tlast}),
    .s_valid (s_axis_tvalid),
    .s_ready (s_axis_tready),
    .m_data  (m_beat),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready)
  );

  assign {m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast} = m_beat;

`ifdef STAMP_INSERTER_STATS_EN
  logic [STATS_WIDTH-1:0] pkt_q;
  logic [STATS_WIDTH-1:0] stall_q;

  // Clear wins over a coincident increment.
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      pkt_q   <= '0;
      stall_q <= '0;
    end else if (clr_stats) begin
      pkt_q   <= '0;
      stall_q <= '0;
    end else begin
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
        pkt_q <= sat_inc(pkt_q);
      end
      if (m_axis_tvalid && !m_axis_tready) begin
        stall_q <= sat_inc(stall_q);
      end
    end
  end

  assign pkt_count   = pkt_q;
  assign stall_count = stall_q;
`else
  logic unused_clr_stats;
  assign unused_clr_stats = clr_stats;
  assign pkt_count        = '0;
  assign stall_count      = '0;
`endif

endmodule

// File: tb/tb_nf10_stamp_inserter.sv
// Scoreboard bench for nf10_stamp_inserter; honours STAMP_INSERTER_STATS_EN for counter checks.
module tb_nf10_stamp_inserter;

  logic         clk;
  logic         axi_reset;
  logic [63:0]  stamp_counter;
  logic [255:0] s_axis_tdata;
  logic [31:0]  s_axis_tstrb;
  logic [127:0] s_axis_tuser;
  logic         s_axis_tvalid;
  logic         s_axis_tlast;
  logic         s_axis_tready;
  logic [255:0] m_axis_tdata;
  logic [31:0]  m_axis_tstrb;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tlast;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         clr_stats;
  logic [31:0]  pkt_count;
  logic [31:0]  stall_count;

  typedef struct {
    logic [255:0] d;
    logic [31:0]  s;
    logic [127:0] u;
    logic         l;
    int           cyc;
    bit           lat;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  bit           stalled = 1'b0;
  logic [416:0] hold;

  nf10_stamp_inserter dut (
    .axi_aclk      (clk),
    .axi_reset     (axi_reset),
    .stamp_counter (stamp_counter),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tstrb  (s_axis_tstrb),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .clr_stats     (clr_stats),
    .pkt_count     (pkt_count),
    .stall_count   (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [255:0] d_of(input int i);
    return {8{32'hD000_0000 + 32'(i)}};
  endfunction

  function automatic logic [127:0] u_of(input int i);
    return {64'hCAFE_0000_0000_0000 | 64'(i), 64'h1234_5678_0000_0000 | 64'(i)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_stats(input string tag, input logic [31:0] p, input logic [31:0] s);
`ifdef STAMP_INSERTER_STATS_EN
    chk({tag, "_pkt_count"}, 64'(pkt_count), 64'(p));
    chk({tag, "_stall_count"}, 64'(stall_count), 64'(s));
`else
    chk({tag, "_pkt_count"}, 64'(pkt_count), 64'(p & 32'h0));
    chk({tag, "_stall_count"}, 64'(stall_count), 64'(s & 32'h0));
`endif
  endtask

  // Present one beat at a negedge; the expected output is queued once the DUT is ready to take it.
  task automatic send_beat(input logic [255:0] d, input logic [31:0] s, input logic [127:0] u,
                           input logic l, input logic [63:0] st, input bit first, input bit lat);
    exp_t e;
    int   n;
    @(negedge clk);
    s_axis_tdata  = d;
    s_axis_tstrb  = s;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    stamp_counter = st;
    n = 0;
    while (!s_axis_tready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!s_axis_tready) begin
      errors++;
      $display("FAIL ready_timeout: s_axis_tready stayed %b, required 1", s_axis_tready);
    end else begin
      e.d = d;
      e.s = s;
      e.u = u;
      if (first) e.u[127:64] = st;
      e.l   = l;
      e.cyc = cyc;
      e.lat = lat;
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      #2;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d beats outstanding, required 0", name, sb.size());
    end
  endtask

  // Monitor: pops and compares on every master handshake, checks hold stability while stalled.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (axi_reset) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        checks++;
        if (!m_axis_tvalid || hold !== {m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast}) begin
          errors++;
          $display("FAIL hold_stable: valid %b user %h, required valid 1 user %h",
                   m_axis_tvalid, m_axis_tuser, hold[128:1]);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got user %h with empty scoreboard", m_axis_tuser);
        end else begin
          e = sb.pop_front();
          if (m_axis_tdata !== e.d || m_axis_tstrb !== e.s || m_axis_tuser !== e.u || m_axis_tlast !== e.l) begin
            errors++;
            $display("FAIL beat: got d %h s %h u %h l %b, required d %h s %h u %h l %b",
                     m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast, e.d, e.s, e.u, e.l);
          end
          if (e.lat) begin
            checks++;
            if (cyc != e.cyc + 1) begin
              errors++;
              $display("FAIL latency: got %0d cycles, required 1", cyc - e.cyc);
            end
          end
        end
      end
      stalled = m_axis_tvalid && !m_axis_tready;
      hold    = {m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    axi_reset     = 1'b1;
    stamp_counter = 64'h0;
    s_axis_tdata  = '0;
    s_axis_tstrb  = '0;
    s_axis_tuser  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    clr_stats     = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_s_tready", 64'(s_axis_tready), 64'd0);
    check_stats("rst", 32'd0, 32'd0);
    #1 axi_reset = 1'b0;
    @(negedge clk);
    chk("post_rst_s_tready", 64'(s_axis_tready), 64'd1);
    chk("post_rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);

    // 3-beat packet, stamp 0x100 on the first beat only, 1-cycle latency
    send_beat(d_of(1), 32'hFFFF_FFFF, u_of(1), 1'b0, 64'h100, 1'b1, 1'b1);
    send_beat(d_of(2), 32'hFFFF_FFFF, u_of(2), 1'b0, 64'h101, 1'b0, 1'b1);
    send_beat(d_of(3), 32'h0000_00FF, u_of(3), 1'b1, 64'h102, 1'b0, 1'b1);
    idle();
    wait_drain("pkt3");
    check_stats("pkt3", 32'd1, 32'd0);

    // Back-to-back single-beat packets
    for (int i = 0; i < 3; i++)
      send_beat(d_of(16 + i), 32'hFFFF_FFFF, u_of(16 + i), 1'b1, 64'h10 + 64'(i), 1'b1, 1'b1);
    idle();
    wait_drain("single");
    check_stats("single", 32'd4, 32'd0);

    // 4-beat packet with 5 cycles of master back-pressure
    @(negedge clk);
    m_axis_tready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send_beat(d_of(32 + i), 32'hFFFF_FFFF, u_of(32 + i), 1'(i == 3), 64'h200 + 64'(i), 1'(i == 0), 1'b0);
        idle();
      end
      begin
        int n;
        n = 0;
        while (!m_axis_tvalid && n < 50) begin
          @(negedge clk);
          n++;
        end
        chk("bp_tvalid_seen", 64'(m_axis_tvalid), 64'd1);
        for (int k = 1; k <= 5; k++) begin
          @(negedge clk);
          if (k == 2) begin
            #1 chk("bp_s_tready_low", 64'(s_axis_tready), 64'd0);
          end
        end
        m_axis_tready = 1'b1;
      end
    join
    wait_drain("bp");
    check_stats("bp", 32'd5, 32'd5);

    // Stamp counter wrap forwarded as sampled
    send_beat(d_of(48), 32'hFFFF_FFFF, u_of(48), 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    send_beat(d_of(49), 32'hFFFF_FFFF, u_of(49), 1'b1, 64'h0, 1'b1, 1'b0);
    idle();
    wait_drain("wrap");
    check_stats("wrap", 32'd7, 32'd5);

    // Reset mid-packet after 2 of 5 beats
    @(negedge clk);
    m_axis_tready = 1'b0;
    send_beat(d_of(64), 32'hFFFF_FFFF, u_of(64), 1'b0, 64'h300, 1'b1, 1'b0);
    send_beat(d_of(65), 32'hFFFF_FFFF, u_of(65), 1'b0, 64'h301, 1'b0, 1'b0);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    #1 chk("pre_rst_m_tvalid", 64'(m_axis_tvalid), 64'd1);
    #1 axi_reset = 1'b1;
    #1;
    chk("mid_rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("mid_rst_s_tready", 64'(s_axis_tready), 64'd0);
    check_stats("mid_rst", 32'd0, 32'd0);
    sb.delete();
    @(negedge clk);
    #2 axi_reset = 1'b0;
    m_axis_tready = 1'b1;
    send_beat(d_of(66), 32'hFFFF_FFFF, u_of(66), 1'b0, 64'h777, 1'b1, 1'b0);
    send_beat(d_of(67), 32'h0000_000F, u_of(67), 1'b1, 64'h778, 1'b0, 1'b0);
    idle();
    wait_drain("after_rst");
    check_stats("after_rst", 32'd1, 32'd0);

    // Stats: clear, 1000 packets, then clear coinciding with a tlast master accept
    @(negedge clk);
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    #2 check_stats("clr_idle", 32'd0, 32'd0);
    for (int i = 0; i < 1000; i++)
      send_beat(d_of(i), 32'hFFFF_FFFF, u_of(i), 1'b1, 64'h1000 + 64'(i), 1'b1, 1'b0);
    idle();
    wait_drain("k_pkts");
    check_stats("k_pkts", 32'd1000, 32'd0);
    send_beat(d_of(2000), 32'hFFFF_FFFF, u_of(2000), 1'b1, 64'hABC, 1'b1, 1'b0);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    clr_stats     = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    wait_drain("clr_last");
    check_stats("clr_last", 32'd0, 32'd0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
